spi_slave_param: RTL and testbench

- Parametrised next-generation SPI slave; SPI serial clock used directly as the block clock.
- Deserialises command/address/write frames from MOSI into a parallel word for the downstream memory/register-file.
- Serialises read data from the memory back onto MISO.
- Adds over the previous generation: configurable payload width, read-data handshake wait, one-cycle rx_valid pulse, aborted-frame error flag, and an explicit read-address-pending flag.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_shift_reg.sv | 34 +++
 rtl/spi_slave_param.sv | 156 +++++++++++++++
 tb/tb_spi_slave_param.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: FSM states, mode-bit values and default widths.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA,
    RD_WAIT,
    RD_TX,
    DONE
  } spi_state_e;

  localparam logic MODE_WRITE = 1'b0;
  localparam logic MODE_READ  = 1'b1;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_CMD_W  = 2;

endpackage

// File: rtl/spi_shift_reg.sv
// MSB-first shift register with synchronous clear, parallel load and shift-in.
// Exposes the MSB and the bits below it separately so each user taps only what it needs.
module spi_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load_en,
  input  logic             shift_en,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] load_data,
  output logic             msb,
  output logic [WIDTH-2:0] rest
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load_en) begin
      q <= load_data;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], serial_in};
    end
  end

  assign msb  = q[WIDTH-1];
  assign rest = q[WIDTH-2:0];

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: receives {cmd, payload} frames on MOSI and returns
// handshaked read data on MISO, clocked directly by the SPI serial clock.
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CMD_W  = DEF_CMD_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    SS_n,
  input  logic                    MOSI,
  output logic                    MISO,
  output logic [CMD_W+DATA_W-1:0] rx_data,
  output logic                    rx_valid,
  input  logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_valid,
  output logic                    frame_err,
  output logic                    rd_addr_pending
);

  localparam int unsigned RX_W  = CMD_W + DATA_W;
  localparam int unsigned RXC_W = $clog2(RX_W + 1);
  localparam int unsigned TXC_W = $clog2(DATA_W + 1);

  spi_state_e state, next_state;

  logic [RXC_W-1:0] bit_cnt;
  logic [TXC_W-1:0] tx_cnt;

  logic rx_shift, rx_done;
  logic tx_load, tx_shift, tx_done;
  logic abort, abort_err;
  logic set_pend, clr_pend;

  logic            rx_msb_unused;
  logic [RX_W-2:0] rx_rest;
  logic [DATA_W-2:0] tx_rest_unused;

  spi_shift_reg #(.WIDTH(RX_W)) u_rx_sr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (1'b0),
    .load_en   (1'b0),
    .shift_en  (rx_shift),
    .serial_in (MOSI),
    .load_data ('0),
    .msb       (rx_msb_unused),
    .rest      (rx_rest)
  );

  // MISO is the TX register MSB; zeros shift in behind the data so it idles low after the LSB.
  spi_shift_reg #(.WIDTH(DATA_W)) u_tx_sr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (abort),
    .load_en   (tx_load),
    .shift_en  (tx_shift),
    .serial_in (1'b0),
    .load_data (tx_data),
    .msb       (MISO),
    .rest      (tx_rest_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    rx_shift   = 1'b0;
    rx_done    = 1'b0;
    tx_load    = 1'b0;
    tx_shift   = 1'b0;
    tx_done    = 1'b0;
    abort      = 1'b0;
    abort_err  = 1'b0;
    set_pend   = 1'b0;
    clr_pend   = 1'b0;

    if (state != IDLE && SS_n) begin
      next_state = IDLE;
      abort      = 1'b1;
      abort_err  = (state inside {WRITE, READ_ADD, READ_DATA});
    end else begin
      case (state)
        IDLE: begin
          if (!SS_n) next_state = CHK_CMD;
        end
        CHK_CMD: begin
          if (MOSI == MODE_WRITE)   next_state = WRITE;
          else if (rd_addr_pending) next_state = READ_DATA;
          else                      next_state = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          rx_shift = 1'b1;
          if (bit_cnt == RXC_W'(RX_W - 1)) begin
            rx_done    = 1'b1;
            set_pend   = (state == READ_ADD);
            next_state = (state == READ_DATA) ? RD_WAIT : DONE;
          end
        end
        RD_WAIT: begin
          if (tx_valid) begin
            tx_load    = 1'b1;
            next_state = RD_TX;
          end
        end
        RD_TX: begin
          tx_shift = 1'b1;
          if (tx_cnt == TXC_W'(DATA_W)) begin
            tx_done    = 1'b1;
            clr_pend   = 1'b1;
            next_state = DONE;
          end
        end
        DONE: begin
          next_state = DONE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data         <= '0;
      rx_valid        <= 1'b0;
      frame_err       <= 1'b0;
      rd_addr_pending <= 1'b0;
      bit_cnt         <= '0;
      tx_cnt          <= '0;
    end else begin
      rx_valid  <= rx_done;
      frame_err <= abort_err;

      if (rx_done) rx_data <= {rx_rest, MOSI};

      if (set_pend)      rd_addr_pending <= 1'b1;
      else if (clr_pend) rd_addr_pending <= 1'b0;

      if (state == IDLE)  bit_cnt <= '0;
      else if (rx_shift)  bit_cnt <= bit_cnt + RXC_W'(1);

      // tx_cnt counts bits already presented on MISO; the load edge presents the first.
      if (state == IDLE)              tx_cnt <= '0;
      else if (tx_load)               tx_cnt <= TXC_W'(1);
      else if (tx_shift && !tx_done)  tx_cnt <= tx_cnt + TXC_W'(1);
    end
  end

endmodule

// File: tb/tb_spi_slave_param.sv
// Self-checking bench for spi_slave_param: directed frame table, reset/abort
// sequences, then random frames checked against a frame-level reference model.
module tb_spi_slave_param;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CMD_W  = 2;
  localparam int unsigned RX_W   = CMD_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              SS_n = 1'b1;
  logic              MOSI = 1'b0;
  logic              MISO;
  logic [RX_W-1:0]   rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data = '0;
  logic              tx_valid = 1'b0;
  logic              frame_err;
  logic              rd_addr_pending;

  spi_slave_param #(.DATA_W(DATA_W), .CMD_W(CMD_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .SS_n            (SS_n),
    .MOSI            (MOSI),
    .MISO            (MISO),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .frame_err       (frame_err),
    .rd_addr_pending (rd_addr_pending)
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned both_cnt = 0;

  typedef struct {
    logic              mode;
    logic [RX_W-1:0]   frame;
    int                abort_at;   // -1: full frame, else SS_n rises instead of bit abort_at
    int                wait_n;
    logic [DATA_W-1:0] tx;
    logic [RX_W-1:0]   exp_rx;
    int                exp_valid;
    int                exp_err;
    logic              exp_pend;
    logic              exp_rd;
    logic [DATA_W-1:0] exp_miso;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rx_valid && frame_err) both_cnt++;
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int valid_cnt = 0;
    int err_cnt = 0;
    int stray = 0;
    logic on_time = 1'b0;
    logic [DATA_W-1:0] miso_word = '0;

    SS_n = 1'b0;
    tick();
    valid_cnt += int'(rx_valid); err_cnt += int'(frame_err); stray += int'(MISO);
    MOSI = v.mode;
    tick();
    valid_cnt += int'(rx_valid); err_cnt += int'(frame_err); stray += int'(MISO);
    for (int i = 0; i < int'(RX_W); i++) begin
      if (i == v.abort_at) break;
      MOSI = v.frame[RX_W-1-i];
      tick();
      if (i == int'(RX_W) - 1 && rx_valid) on_time = 1'b1;
      valid_cnt += int'(rx_valid); err_cnt += int'(frame_err); stray += int'(MISO);
    end
    if (v.abort_at >= 0) begin
      SS_n = 1'b1;
      MOSI = 1'($urandom);
      tick();
      check({tag, " err_on_abort_edge"}, 32'(frame_err), 32'd1);
      valid_cnt += int'(rx_valid); err_cnt += int'(frame_err); stray += int'(MISO);
      tick();
      valid_cnt += int'(rx_valid); err_cnt += int'(frame_err); stray += int'(MISO);
    end else begin
      if (v.exp_rd) begin
        for (int w = 0; w < v.wait_n; w++) begin
          MOSI = 1'($urandom);
          tick();
          valid_cnt += int'(rx_valid); err_cnt += int'(frame_err); stray += int'(MISO);
        end
        tx_data  = v.tx;
        tx_valid = 1'b1;
        for (int b = 0; b < int'(DATA_W); b++) begin
          tick();
          valid_cnt += int'(rx_valid); err_cnt += int'(frame_err);
          miso_word = {miso_word[DATA_W-2:0], MISO};
          tx_valid  = 1'b0;
          tx_data   = DATA_W'($urandom);
        end
        tick();
        valid_cnt += int'(rx_valid); err_cnt += int'(frame_err); stray += int'(MISO);
        check({tag, " miso_word"}, 32'(miso_word), 32'(v.exp_miso));
      end
      for (int d = 0; d < 2; d++) begin
        MOSI = 1'($urandom);
        tick();
        valid_cnt += int'(rx_valid); err_cnt += int'(frame_err); stray += int'(MISO);
      end
      SS_n = 1'b1;
      tick();
      valid_cnt += int'(rx_valid); err_cnt += int'(frame_err); stray += int'(MISO);
    end
    check({tag, " rx_data"}, 32'(rx_data), 32'(v.exp_rx));
    check({tag, " rx_valid_pulses"}, 32'(valid_cnt), 32'(v.exp_valid));
    if (v.exp_valid == 1) check({tag, " rx_valid_timing"}, 32'(on_time), 32'd1);
    check({tag, " frame_err_pulses"}, 32'(err_cnt), 32'(v.exp_err));
    check({tag, " rd_addr_pending"}, 32'(rd_addr_pending), 32'(v.exp_pend));
    check({tag, " miso_idle"}, 32'(stray), 32'd0);
  endtask

  function automatic vec_t mk(input logic mode, input logic [RX_W-1:0] frame, input int abort_at,
                              input int wait_n, input logic [DATA_W-1:0] tx,
                              input logic [RX_W-1:0] exp_rx, input int exp_valid, input int exp_err,
                              input logic exp_pend, input logic exp_rd, input logic [DATA_W-1:0] exp_miso);
    vec_t v;
    v.mode = mode; v.frame = frame; v.abort_at = abort_at; v.wait_n = wait_n; v.tx = tx;
    v.exp_rx = exp_rx; v.exp_valid = exp_valid; v.exp_err = exp_err;
    v.exp_pend = exp_pend; v.exp_rd = exp_rd; v.exp_miso = exp_miso;
    return v;
  endfunction

  vec_t table_v[$];
  logic              pend_m;
  logic [RX_W-1:0]   last_rx_m;

  initial begin
    vec_t v;

    // Reset state
    rst_n = 1'b0;
    repeat (2) tick();
    check("reset MISO", 32'(MISO), 32'd0);
    check("reset rx_data", 32'(rx_data), 32'd0);
    check("reset rx_valid", 32'(rx_valid), 32'd0);
    check("reset frame_err", 32'(frame_err), 32'd0);
    check("reset rd_addr_pending", 32'(rd_addr_pending), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed frames: mode, frame, abort_at, wait, tx | rx, valid, err, pend, rd, miso
    table_v.push_back(mk(1'b0, 10'h0A5, -1, 0, 8'h00, 10'h0A5, 1, 0, 1'b0, 1'b0, 8'h00));
    table_v.push_back(mk(1'b1, 10'h213, -1, 0, 8'h00, 10'h213, 1, 0, 1'b1, 1'b0, 8'h00));
    table_v.push_back(mk(1'b1, 10'h3C5, -1, 5, 8'hC3, 10'h3C5, 1, 0, 1'b0, 1'b1, 8'hC3));
    table_v.push_back(mk(1'b0, 10'h0FF,  6, 0, 8'h00, 10'h3C5, 0, 1, 1'b0, 1'b0, 8'h00));
    table_v.push_back(mk(1'b0, 10'h0A5, -1, 0, 8'h00, 10'h0A5, 1, 0, 1'b0, 1'b0, 8'h00));
    table_v.push_back(mk(1'b0, 10'h3FF, -1, 0, 8'h00, 10'h3FF, 1, 0, 1'b0, 1'b0, 8'h00));
    table_v.push_back(mk(1'b1, 10'h000,  0, 0, 8'h00, 10'h3FF, 0, 1, 1'b0, 1'b0, 8'h00));
    table_v.push_back(mk(1'b1, 10'h001, -1, 0, 8'h00, 10'h001, 1, 0, 1'b1, 1'b0, 8'h00));
    table_v.push_back(mk(1'b1, 10'h2AA,  9, 0, 8'h00, 10'h001, 0, 1, 1'b1, 1'b0, 8'h00));
    table_v.push_back(mk(1'b1, 10'h3F0, -1, 0, 8'h5A, 10'h3F0, 1, 0, 1'b0, 1'b1, 8'h5A));
    foreach (table_v[k]) run_frame(table_v[k], $sformatf("vec%0d", k));

    // Async reset in the middle of RD_TX
    run_frame(mk(1'b1, 10'h111, -1, 0, 8'h00, 10'h111, 1, 0, 1'b1, 1'b0, 8'h00), "rst_setup");
    SS_n = 1'b0; tick();
    MOSI = 1'b1; tick();
    for (int i = 0; i < int'(RX_W); i++) begin MOSI = 1'($urandom); tick(); end
    tx_data = 8'hFF; tx_valid = 1'b1; tick();
    tx_valid = 1'b0; tick(); tick();
    check("pre_reset MISO", 32'(MISO), 32'd1);
    check("pre_reset pending", 32'(rd_addr_pending), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst MISO", 32'(MISO), 32'd0);
    check("async_rst rx_data", 32'(rx_data), 32'd0);
    check("async_rst rx_valid", 32'(rx_valid), 32'd0);
    check("async_rst frame_err", 32'(frame_err), 32'd0);
    check("async_rst pending", 32'(rd_addr_pending), 32'd0);
    SS_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_frame(mk(1'b1, 10'h155, -1, 0, 8'h00, 10'h155, 1, 0, 1'b1, 1'b0, 8'h00), "post_rst_read_add");

    // SS_n abort during RD_TX: no frame_err, pending kept, MISO forced low
    SS_n = 1'b0; tick();
    MOSI = 1'b1; tick();
    for (int i = 0; i < int'(RX_W); i++) begin
      v.frame = 10'h3AB;
      MOSI = v.frame[RX_W-1-i];
      tick();
    end
    tx_data = 8'hA5; tx_valid = 1'b1; tick();
    tx_valid = 1'b0; tick(); tick();
    check("txabort MISO_before", 32'(MISO), 32'd1);
    SS_n = 1'b1; tick();
    check("txabort MISO", 32'(MISO), 32'd0);
    check("txabort frame_err", 32'(frame_err), 32'd0);
    check("txabort pending", 32'(rd_addr_pending), 32'd1);
    check("txabort rx_data", 32'(rx_data), 32'h3AB);

    // Random frames against the frame-level model
    pend_m    = 1'b1;
    last_rx_m = 10'h3AB;
    for (int n = 0; n < 40; n++) begin
      v.mode     = 1'($urandom);
      v.frame    = RX_W'($urandom);
      v.abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, RX_W - 1)) : -1;
      v.wait_n   = int'($urandom_range(0, 6));
      v.tx       = DATA_W'($urandom);
      v.exp_miso = v.tx;
      v.exp_rd   = 1'b0;
      if (v.abort_at >= 0) begin
        v.exp_valid = 0;
        v.exp_err   = 1;
      end else begin
        v.exp_valid = 1;
        v.exp_err   = 0;
        last_rx_m   = v.frame;
        if (v.mode == 1'b1) begin
          v.exp_rd = pend_m;
          pend_m   = !pend_m;
        end
      end
      v.exp_rx   = last_rx_m;
      v.exp_pend = pend_m;
      run_frame(v, $sformatf("rnd%0d", n));
    end

    check("rx_valid_and_frame_err_overlap", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
